spi_calc_master: RTL

- Host-side SPI master that drives the calculator peripheral's serial port: `sclk_o`, `mosi_o`, `cs_o` out, `miso_i` in.
- Converts a parallel request (8-bit address, 16-bit data) into one 32-bit frame.
- Returns the 32 bits shifted in on `miso_i` as a parallel word.
- Sits directly upstream of the SPI peripheral, between the system controller and the serial link.

---
 rtl/spi_calc_master.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_calc_master.sv
// ---------------------------------------------------------------------------
// spi_calc_master
//
// Host-side SPI master for the calculator peripheral. A parallel request
// (8-bit address, 16-bit data) becomes one 32-bit frame {8'h00, addr, data}.
// The frame is shifted out MSB first on mosi_o. The 32 bits sampled on
// miso_i come back as a parallel word on rdata_o.
//
// SCLK is idle low. MOSI changes only on SCLK rise. MISO is sampled only on
// SCLK fall. Each frame is followed by an inter-frame gap with cs_o high.
//
// Parameters:
//   CLK_DIV    clk_i cycles per SCLK half-period (>= 1)
//   GAP_CYCLES minimum clk_i cycles cs_o stays high between frames (>= 1)
//   CNT_W      half-period / gap counter width, holds max(CLK_DIV, GAP_CYCLES)
//
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   start_i  request strobe, accepted only while busy_o = 0
//   addr_i   register address (0x00 reset, 0x01 operate)
//   data_i   write data (operate: [15:8] = A, [7:0] = B)
//   busy_o   frame or inter-frame gap in progress
//   done_o   one-cycle pulse at end of frame
//   rdata_o  word received on MISO ([16] peripheral busy, [15:0] result)
//   sclk_o   serial clock, idle low
//   mosi_o   serial data out, MSB first
//   cs_o     chip select, active low
//   miso_i   serial data in
//
// Optional build macro: SPI_CALC_MASTER_IDLE_SCLK_EN
//   When defined, sclk_o free-runs (toggling every CLK_DIV cycles) in IDLE
//   and GAP with cs_o = 1 and mosi_o = 0. This keeps the SCLK-clocked
//   calculator core advancing between frames. An accepted request waits
//   for sclk_o = 0 before the frame starts, so cs_o never moves while SCLK
//   is high.
// ---------------------------------------------------------------------------
module spi_calc_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  addr_i,
    input  logic [15:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        cs_o,
    input  logic        miso_i
);

    // FSM encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [5:0]       LAST_BIT  = 6'd31;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      tx_q,      tx_d;
    logic [31:0]      rx_q,      rx_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic             sclk_q,    sclk_d;
    logic             mosi_q,    mosi_d;
    logic             cs_q,      cs_d;

    logic             half_done;
    logic             gap_done;
    logic [31:0]      frame;

    assign half_done = (cnt_q == HALF_LAST);
    assign gap_done  = (cnt_q == GAP_LAST);
    assign frame     = {8'h00, addr_i, data_i};

`ifdef SPI_CALC_MASTER_IDLE_SCLK_EN
    // Divider for the free-running SCLK outside frames.
    logic [CNT_W-1:0] div_q, div_d;
    logic             idle_tick;

    assign idle_tick = (div_q == HALF_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
`ifdef SPI_CALC_MASTER_IDLE_SCLK_EN
        div_d     = '0;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
`ifdef SPI_CALC_MASTER_IDLE_SCLK_EN
                div_d = idle_tick ? '0 : div_q + 1'b1;
                if (idle_tick) begin
                    sclk_d = ~sclk_q;
                end
                // busy_q high in IDLE means a request is latched and
                // waiting for the free-running SCLK to reach its low phase.
                if (start_i && !busy_q) begin
                    busy_d = 1'b1;
                    tx_d   = frame;
                end
                if ((start_i || busy_q) && !sclk_q) begin
                    state_d   = S_SETUP;
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = 1'b0;
                    bit_cnt_d = '0;
                    div_d     = '0;
                end
`else
                if (start_i) begin
                    busy_d    = 1'b1;
                    tx_d      = frame;
                    state_d   = S_SETUP;
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = 1'b0;
                    bit_cnt_d = '0;
                end
`endif
            end

            // SETUP and LOW both end with an SCLK rise that presents the
            // next frame bit, so they share one branch.
            S_SETUP, S_LOW: begin
                if (half_done) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    mosi_d  = tx_q[31];
                    tx_d    = {tx_q[30:0], 1'b0};
                    state_d = S_HIGH;
                end
            end

            S_HIGH: begin
                if (half_done) begin
                    cnt_d     = '0;
                    sclk_d    = 1'b0;
                    rx_d      = {rx_q[30:0], miso_i};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? S_END : S_LOW;
                end
            end

            // Hold CS low for one more half-period after the last fall so
            // the peripheral sees a full low phase before deselect.
            S_END: begin
                if (half_done) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    rdata_d = rx_q;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
`ifdef SPI_CALC_MASTER_IDLE_SCLK_EN
                div_d = idle_tick ? '0 : div_q + 1'b1;
                if (idle_tick) begin
                    sclk_d = ~sclk_q;
                end
`endif
                if (gap_done) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
`ifdef SPI_CALC_MASTER_IDLE_SCLK_EN
            div_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
`ifdef SPI_CALC_MASTER_IDLE_SCLK_EN
            div_q     <= div_d;
`endif
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign sclk_o  = sclk_q;
    assign mosi_o  = mosi_q;
    assign cs_o    = cs_q;

endmodule
